// File: rtl/counter_pkg.sv
// counter_pkg: shared counter width and compare-stage state type.
//    CNT_WIDTH   - width of simple_counter data and of every consumer's compare path
//    cmp_state_t - compare FSM states
package counter_pkg;
   localparam int CNT_WIDTH = 16;
   typedef enum logic [1:0] {DISARMED, ARMED, FIRED} cmp_state_t;
endpackage

// File: rtl/count_edge_detect.sv
// count_edge_detect: registers the previous count and flags change and period boundary.
//    clk, nreset   - clock, synchronous active-low reset
//    i_count       - live counter value
//    o_changed     - count differs from previous cycle
//    o_boundary    - count went down (wrap or counter reset)
module count_edge_detect
   import counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [WIDTH-1:0] i_count,
   output logic             o_changed,
   output logic             o_boundary
);
   logic [WIDTH-1:0] r_count_q;
   always_ff @(posedge clk)
      r_count_q <= !nreset ? '0 : i_count;
   assign o_changed  = i_count != r_count_q;
   assign o_boundary = i_count < r_count_q;
endmodule

// File: rtl/counter_compare_unit.sv
// counter_compare_unit: compare/PWM stage with shadowed config, match pulse and saturating tally.
//    clk, nreset             - clock, synchronous active-low reset
//    i_count                 - live counter value
//    i_cfg_valid/o_cfg_ready - config handshake
//    i_cfg_compare           - compare value, sampled on handshake
//    i_cfg_oneshot           - disarm after first match, sampled on handshake
//    o_match                 - registered one-cycle match pulse
//    o_pwm_out               - registered PWM level (count < compare while armed)
//    o_armed                 - FSM is ARMED
//    o_match_tally           - saturating count of match pulses
module counter_compare_unit
   import counter_pkg::*;
#(
   parameter int WIDTH       = CNT_WIDTH,
   parameter int TALLY_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   nreset,
   input  logic [WIDTH-1:0]       i_count,
   input  logic                   i_cfg_valid,
   output logic                   o_cfg_ready,
   input  logic [WIDTH-1:0]       i_cfg_compare,
   input  logic                   i_cfg_oneshot,
   output logic                   o_match,
   output logic                   o_pwm_out,
   output logic                   o_armed,
   output logic [TALLY_WIDTH-1:0] o_match_tally
);
   cmp_state_t             r_state, w_next_state;
   logic [WIDTH-1:0]       r_active_cmp, r_shadow_cmp;
   logic                   r_active_oneshot, r_shadow_oneshot, r_pending;
   logic                   r_match, r_pwm;
   logic [TALLY_WIDTH-1:0] r_tally;
   logic                   w_changed, w_boundary, w_xfer, w_to_shadow, w_match;

   count_edge_detect #(.WIDTH(WIDTH)) u_edge (
      .clk        (clk),
      .nreset     (nreset),
      .i_count    (i_count),
      .o_changed  (w_changed),
      .o_boundary (w_boundary)
   );

   assign w_xfer      = i_cfg_valid && !r_pending;
   assign w_to_shadow = w_xfer && r_state == ARMED;
   assign w_match     = r_state == ARMED && w_changed && i_count == r_active_cmp;

   always_ff @(posedge clk)
      r_state <= !nreset ? DISARMED : w_next_state;

   always_comb
      w_next_state = (r_state == ARMED) ? ((w_match && r_active_oneshot) ? FIRED : ARMED)
                                        : (w_xfer ? ARMED : r_state);

   always_comb
      o_armed = r_state == ARMED;

   // The shadow is drained on a boundary in FIRED as well: a oneshot can fire
   // while a config is pending, and the handshake must not stay blocked.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_active_cmp     <= '0;
         r_active_oneshot <= 1'b0;
         r_shadow_cmp     <= '0;
         r_shadow_oneshot <= 1'b0;
         r_pending        <= 1'b0;
         r_match          <= 1'b0;
         r_pwm            <= 1'b0;
         r_tally          <= '0;
      end else begin
         if (w_xfer && !w_to_shadow) begin
            r_active_cmp     <= i_cfg_compare;
            r_active_oneshot <= i_cfg_oneshot;
         end else if (w_boundary && r_pending) begin
            r_active_cmp     <= r_shadow_cmp;
            r_active_oneshot <= r_shadow_oneshot;
         end
         if (w_to_shadow) begin
            r_shadow_cmp     <= i_cfg_compare;
            r_shadow_oneshot <= i_cfg_oneshot;
         end
         r_pending <= w_to_shadow ? 1'b1 : (w_boundary ? 1'b0 : r_pending);
         r_match   <= w_match;
         r_pwm     <= r_state == ARMED && i_count < r_active_cmp;
         r_tally   <= (w_match && !(&r_tally)) ? r_tally + TALLY_WIDTH'(1) : r_tally;
      end
   end

   assign o_cfg_ready   = !r_pending;
   assign o_match       = r_match;
   assign o_pwm_out     = r_pwm;
   assign o_match_tally = r_tally;
endmodule
